// File: rtl/alu_mdu.sv
`default_nettype none
// ============================================================================
// Module   : alu_mdu
// Purpose  : EX-stage integer/branch ALU with a registered 1-cycle result,
//            plus iterative RV32M multiply/divide with fixed XLEN+1 latency.
//            Build macro ALU_MDU_DIV_EN enables the divider (ops 20-23).
// Revision : 1.0 - initial release
// ============================================================================
module alu_mdu #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN),
    parameter int OP_W    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic            alub_sel,
    input  logic [OP_W-1:0] alu_op,
    input  logic [XLEN-1:0] rD1,
    input  logic [XLEN-1:0] rD2,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    output logic [XLEN-1:0] C,
    output logic            f
);
    localparam int         c_CNT_W = $clog2(XLEN);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_MUL   = 2'd1;
    localparam logic [1:0] c_FIX   = 2'd3;
`ifdef ALU_MDU_DIV_EN
    localparam logic [1:0] c_DIV   = 2'd2;
`endif

    logic [1:0]         r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_out_valid, r_f, r_neg;
    logic [XLEN-1:0]    r_c, r_hi, r_lo, r_mcand;
    logic [1:0]         r_sub;

    logic [XLEN-1:0]    w_b, w_diff, w_alu_c, w_abs_a, w_abs_b, w_fix;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_alu_f, w_lt, w_ltu, w_eq;
    logic               w_is_mul, w_long, w_last, w_a_signed, w_b_signed, w_sa, w_sb;
    logic [XLEN:0]      w_mul_sum;
    logic [2*XLEN-1:0]  w_prod;

    assign w_b     = alub_sel ? imm : rD2;
    assign w_diff  = rD1 - w_b;
    assign w_shamt = w_b[SHAMT_W-1:0];
    assign w_lt    = $signed(rD1) < $signed(w_b);
    assign w_ltu   = rD1 < w_b;
    assign w_eq    = rD1 == w_b;

    always_comb begin
        w_alu_c = '0;
        w_alu_f = 1'b0;
        case (alu_op)
            OP_W'(0):  w_alu_c = rD1 + w_b;
            OP_W'(1):  w_alu_c = w_diff;
            OP_W'(2):  w_alu_c = rD1 & w_b;
            OP_W'(3):  w_alu_c = rD1 | w_b;
            OP_W'(4):  w_alu_c = rD1 ^ w_b;
            OP_W'(5):  w_alu_c = rD1 << w_shamt;
            OP_W'(6):  w_alu_c = rD1 >> w_shamt;
            OP_W'(7):  w_alu_c = $signed(rD1) >>> w_shamt;
            OP_W'(8):  w_alu_c = {{(XLEN-1){1'b0}}, w_lt};
            OP_W'(9):  w_alu_c = {{(XLEN-1){1'b0}}, w_ltu};
            OP_W'(10): begin w_alu_c = w_diff; w_alu_f = w_eq;   end
            OP_W'(11): begin w_alu_c = w_diff; w_alu_f = ~w_eq;  end
            OP_W'(12): begin w_alu_c = w_diff; w_alu_f = w_lt;   end
            OP_W'(13): begin w_alu_c = w_diff; w_alu_f = ~w_lt;  end
            OP_W'(14): begin w_alu_c = w_diff; w_alu_f = w_ltu;  end
            OP_W'(15): begin w_alu_c = w_diff; w_alu_f = ~w_ltu; end
            default:   ;
        endcase
    end

    // Operands are stored as magnitudes; the sign is restored in FIX.
    assign w_is_mul = (alu_op >= OP_W'(16)) && (alu_op <= OP_W'(19));
`ifdef ALU_MDU_DIV_EN
    logic            w_is_div;
    logic            r_is_div, r_sgn_a, r_b_zero;
    logic [XLEN:0]   w_div_shift, w_div_diff;
    assign w_is_div    = (alu_op >= OP_W'(20)) && (alu_op <= OP_W'(23));
    assign w_long      = w_is_mul | w_is_div;
    assign w_a_signed  = w_is_div ? ~alu_op[0] : (alu_op[1:0] != 2'b11);
    assign w_b_signed  = w_is_div ? ~alu_op[0] : ~alu_op[1];
    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_mcand};
`else
    assign w_long      = w_is_mul;
    assign w_a_signed  = alu_op[1:0] != 2'b11;
    assign w_b_signed  = ~alu_op[1];
`endif
    assign w_sa      = w_a_signed & rD1[XLEN-1];
    assign w_sb      = w_b_signed & w_b[XLEN-1];
    assign w_abs_a   = w_sa ? -rD1 : rD1;
    assign w_abs_b   = w_sb ? -w_b : w_b;
    assign w_last    = r_cnt == c_CNT_W'(XLEN-1);
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(XLEN+1){1'b0}});
    assign w_prod    = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};

    // Signed overflow (MIN / -1) falls out of the magnitude datapath naturally.
    always_comb begin
        w_fix = (r_sub == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
`ifdef ALU_MDU_DIV_EN
        if (r_is_div) begin
            if (r_sub[1])      w_fix = r_sgn_a ? -r_hi : r_hi;
            else if (r_b_zero) w_fix = '1;
            else               w_fix = r_neg ? -r_lo : r_lo;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid && w_is_mul) w_state_nxt = c_MUL;
`ifdef ALU_MDU_DIV_EN
                    if (in_valid && w_is_div) w_state_nxt = c_DIV;
`endif
                end
                c_MUL:   if (w_last) w_state_nxt = c_FIX;
`ifdef ALU_MDU_DIV_EN
                c_DIV:   if (w_last) w_state_nxt = c_FIX;
`endif
                c_FIX:   w_state_nxt = c_IDLE;
                default: w_state_nxt = c_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = (r_state == c_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_c         <= '0;
            r_f         <= 1'b0;
            r_cnt       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_mcand     <= '0;
            r_neg       <= 1'b0;
            r_sub       <= 2'b00;
`ifdef ALU_MDU_DIV_EN
            r_is_div    <= 1'b0;
            r_sgn_a     <= 1'b0;
            r_b_zero    <= 1'b0;
`endif
        end else begin
            r_out_valid <= 1'b0;
            if (flush) begin
                r_cnt <= '0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (in_valid && w_long) begin
                            r_hi     <= '0;
                            r_lo     <= w_abs_a;
                            r_mcand  <= w_abs_b;
                            r_neg    <= w_sa ^ w_sb;
                            r_sub    <= alu_op[1:0];
                            r_cnt    <= '0;
`ifdef ALU_MDU_DIV_EN
                            r_is_div <= w_is_div;
                            r_sgn_a  <= w_sa;
                            r_b_zero <= (w_b == '0);
`endif
                        end else if (in_valid) begin
                            r_c         <= w_alu_c;
                            r_f         <= w_alu_f;
                            r_out_valid <= 1'b1;
                        end
                    end
                    c_MUL: begin
                        r_hi  <= w_mul_sum[XLEN:1];
                        r_lo  <= {w_mul_sum[0], r_lo[XLEN-1:1]};
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
`ifdef ALU_MDU_DIV_EN
                    c_DIV: begin
                        if (!w_div_diff[XLEN]) begin
                            r_hi <= w_div_diff[XLEN-1:0];
                            r_lo <= {r_lo[XLEN-2:0], 1'b1};
                        end else begin
                            r_hi <= w_div_shift[XLEN-1:0];
                            r_lo <= {r_lo[XLEN-2:0], 1'b0};
                        end
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
`endif
                    c_FIX: begin
                        r_c         <= w_fix;
                        r_f         <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign out_valid = r_out_valid;
    assign C         = r_c;
    assign f         = r_f;
endmodule
`default_nettype wire

// File: tb/tb_alu_mdu.sv
`default_nettype none
// Self-checking bench for alu_mdu: random and directed ops against a
// plain-arithmetic reference model, with latency, flush and reset checks.
module tb_alu_mdu;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, alub_sel, out_valid, dut_f;
    logic [4:0]  alu_op;
    logic [31:0] rD1, rD2, imm, dut_c;
    int          total = 0;
    int          bad   = 0;

    alu_mdu #(.XLEN(32), .SHAMT_W(5), .OP_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .alub_sel(alub_sel), .alu_op(alu_op), .rD1(rD1),
        .rD2(rD2), .imm(imm), .out_valid(out_valid), .C(dut_c), .f(dut_f)
    );

    always #5 clk = ~clk;

    // Reference: what each op means arithmetically; lng marks multi-cycle ops.
    function automatic void model(input logic [4:0] op, input logic [31:0] a, b,
                                  output logic [31:0] c, output logic fl, output bit lng);
        int sa, sb;
        longint p;
        logic [63:0] u;
        sa = a; sb = b; c = '0; fl = 1'b0; lng = 1'b0;
        p = longint'(sa) * longint'(sb);
        u = {32'd0, a} * {32'd0, b};
        case (op)
            5'd0:  c = a + b;
            5'd1:  c = a - b;
            5'd2:  c = a & b;
            5'd3:  c = a | b;
            5'd4:  c = a ^ b;
            5'd5:  c = a << b[4:0];
            5'd6:  c = a >> b[4:0];
            5'd7:  c = sa >>> b[4:0];
            5'd8:  c = (sa < sb) ? 1 : 0;
            5'd9:  c = (a < b) ? 1 : 0;
            5'd10: begin c = a - b; fl = (a == b);   end
            5'd11: begin c = a - b; fl = (a != b);   end
            5'd12: begin c = a - b; fl = (sa < sb);  end
            5'd13: begin c = a - b; fl = (sa >= sb); end
            5'd14: begin c = a - b; fl = (a < b);    end
            5'd15: begin c = a - b; fl = (a >= b);   end
            5'd16: begin lng = 1'b1; c = p[31:0];  end
            5'd17: begin lng = 1'b1; c = p[63:32]; end
            5'd18: begin
                lng = 1'b1;
                p = longint'(sa) * longint'({32'd0, b});
                c = p[63:32];
            end
            5'd19: begin lng = 1'b1; c = u[63:32]; end
`ifdef ALU_MDU_DIV_EN
            5'd20: begin
                lng = 1'b1;
                if (b == 0) c = '1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) c = a;
                else c = sa / sb;
            end
            5'd21: begin lng = 1'b1; c = (b == 0) ? '1 : a / b; end
            5'd22: begin
                lng = 1'b1;
                if (b == 0) c = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) c = '0;
                else c = sa % sb;
            end
            5'd23: begin lng = 1'b1; c = (b == 0) ? a : a % b; end
`endif
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Presents one op, then scrambles inputs; edges = extra edges after the
    // accept edge until out_valid is seen (-1 if it never appears).
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, b, input logic sel,
                         output int edges, output logic [31:0] c, output logic fo);
        alu_op = op; rD1 = a; alub_sel = sel;
        if (sel) begin imm = b; rD2 = $urandom; end
        else     begin rD2 = b; imm = $urandom; end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; rD1 = $urandom; rD2 = $urandom; imm = $urandom;
        alu_op = 5'($urandom);
        edges = -1; c = 'x; fo = 1'bx;
        for (int k = 0; k <= 40; k++) begin
            if (out_valid) begin edges = k; c = dut_c; fo = dut_f; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; alub_sel = 1'b0;
        alu_op = '0; rD1 = '0; rD2 = '0; imm = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs: got ready=%b valid=%b, want ready=1 valid=0", in_ready, out_valid);
        end
        total++;
        if (dut_c !== 32'h0 || dut_f !== 1'b0) begin
            bad++;
            $display("FAIL reset_cf: got C=%h f=%b, want C=0 f=0", dut_c, dut_f);
        end
        rst = 1'b0;
    endtask

    task automatic test_simple();
        int e; logic [31:0] c; logic fo;
        logic [4:0]  ops[6] = '{5'd0, 5'd14, 5'd12, 5'd10, 5'd13, 5'd31};
        logic [31:0] as[6]  = '{32'h7FFF_FFFF, 32'd1, 32'd1, 32'd5, 32'd5, 32'h1234_5678};
        logic [31:0] bs[6]  = '{32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5, 32'd9};
        logic        sels[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] ec[6]  = '{32'h8000_0000, 32'd2, 32'd2, 32'd0, 32'd0, 32'd0};
        logic        ef[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            do_op(ops[i], as[i], bs[i], sels[i], e, c, fo);
            total++;
            if (e !== 0 || c !== ec[i] || fo !== ef[i]) begin
                bad++;
                $display("FAIL simple[%0d] op=%0d: got edges=%0d C=%h f=%b, want edges=0 C=%h f=%b",
                         i, ops[i], e, c, fo, ec[i], ef[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  op;
        logic [31:0] a, b, ec;
        logic        ef, sel;
        bit          lng;
        for (int i = 0; i < 40; i++) begin
            if (i == 0)      begin op = 5'd0; a = 32'h7FFF_FFFF; b = 32'd1; sel = 1'b1; end
            else if (i == 1) begin op = 5'd7; a = 32'h8000_0000; b = 32'd4; sel = 1'b0; end
            else begin
                op  = 5'($urandom_range(0, 23));
                if (op > 5'd15) op = op + 5'd8;
                a   = rnd_val(); b = rnd_val(); sel = 1'($urandom);
            end
            alu_op = op; rD1 = a; alub_sel = sel;
            if (sel) begin imm = b; rD2 = $urandom; end
            else     begin rD2 = b; imm = $urandom; end
            in_valid = 1'b1;
            @(posedge clk); #1;
            model(op, a, b, ec, ef, lng);
            total++;
            if (out_valid !== 1'b1 || dut_c !== ec || dut_f !== ef) begin
                bad++;
                $display("FAIL b2b[%0d] op=%0d a=%h b=%h: got v=%b C=%h f=%b, want v=1 C=%h f=%b",
                         i, op, a, b, out_valid, dut_c, dut_f, ec, ef);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul_timing();
        bit ok_busy = 1'b1;
        alu_op = 5'd17; rD1 = 32'hFFFF_FFFF; rD2 = 32'd2; alub_sel = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        // An ADD offered while busy must be ignored.
        alu_op = 5'd0; rD1 = 32'd100; rD2 = 32'd200;
        for (int k = 0; k <= 32; k++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) ok_busy = 1'b0;
            if (k == 32) in_valid = 1'b0;
            @(posedge clk); #1;
        end
        total++;
        if (ok_busy !== 1'b1) begin
            bad++;
            $display("FAIL mulh_busy: got ready/valid not held low over 33 cycles, want ready=0 valid=0");
        end
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || dut_c !== 32'hFFFF_FFFF || dut_f !== 1'b0) begin
            bad++;
            $display("FAIL mulh_done: got v=%b ready=%b C=%h f=%b, want v=1 ready=1 C=ffffffff f=0",
                     out_valid, in_ready, dut_c, dut_f);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mulh_pulse: got v=%b one cycle later, want v=0", out_valid);
        end
    endtask

    task automatic test_mul_random();
        int e; logic [31:0] c, a, b, ec; logic fo, ef; logic [4:0] op; bit lng;
        do_op(5'd16, 32'd6, 32'd7, 1'b0, e, c, fo);
        total++;
        if (e !== XLEN + 1 || c !== 32'd42) begin
            bad++;
            $display("FAIL mul_6x7: got edges=%0d C=%h, want edges=%0d C=0000002a", e, c, XLEN + 1);
        end
        for (int i = 0; i < 10; i++) begin
            op = 5'd16 + 5'($urandom_range(0, 3));
            a = rnd_val(); b = rnd_val();
            do_op(op, a, b, 1'($urandom), e, c, fo);
            model(op, a, b, ec, ef, lng);
            total++;
            if (e !== XLEN + 1 || c !== ec || fo !== ef) begin
                bad++;
                $display("FAIL mul_rand[%0d] op=%0d a=%h b=%h: got edges=%0d C=%h f=%b, want edges=%0d C=%h f=%b",
                         i, op, a, b, e, c, fo, XLEN + 1, ec, ef);
            end
        end
    endtask

    task automatic test_div();
        int e, ee; logic [31:0] c, a, b, ec; logic fo, ef; logic [4:0] op; bit lng;
        logic [4:0]  ops[5] = '{5'd20, 5'd22, 5'd21, 5'd23, 5'd20};
        logic [31:0] as[5]  = '{32'h8000_0000, 32'h8000_0000, 32'd7, 32'd7, 32'd10};
        logic [31:0] bs[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd2};
`ifdef ALU_MDU_DIV_EN
        logic [31:0] exp[5] = '{32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd7, 32'd5};
        ee = XLEN + 1;
`else
        logic [31:0] exp[5] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        ee = 0;
`endif
        for (int i = 0; i < 5; i++) begin
            do_op(ops[i], as[i], bs[i], 1'b0, e, c, fo);
            total++;
            if (e !== ee || c !== exp[i] || fo !== 1'b0) begin
                bad++;
                $display("FAIL div_dir[%0d] op=%0d: got edges=%0d C=%h f=%b, want edges=%0d C=%h f=0",
                         i, ops[i], e, c, fo, ee, exp[i]);
            end
        end
        for (int i = 0; i < 10; i++) begin
            op = 5'd20 + 5'($urandom_range(0, 3));
            a = rnd_val(); b = rnd_val();
            if (i == 3) b = 32'd0;
            do_op(op, a, b, 1'($urandom), e, c, fo);
            model(op, a, b, ec, ef, lng);
            total++;
            if (e !== (lng ? XLEN + 1 : 0) || c !== ec || fo !== ef) begin
                bad++;
                $display("FAIL div_rand[%0d] op=%0d a=%h b=%h: got edges=%0d C=%h f=%b, want edges=%0d C=%h f=%b",
                         i, op, a, b, e, c, fo, lng ? XLEN + 1 : 0, ec, ef);
            end
        end
    endtask

    task automatic test_flush();
        int e; logic [31:0] c, held; logic fo; bit quiet = 1'b1;
        held = dut_c;
        alu_op = 5'd16; rD1 = 32'd6; rD2 = 32'd7; alub_sel = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut_c !== held) begin
            bad++;
            $display("FAIL flush_mul: got v=%b ready=%b C=%h, want v=0 ready=1 C=%h",
                     out_valid, in_ready, dut_c, held);
        end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (quiet !== 1'b1) begin
            bad++;
            $display("FAIL flush_quiet: got out_valid after flush, want none");
        end
        do_op(5'd0, 32'd2, 32'd3, 1'b0, e, c, fo);
        total++;
        if (e !== 0 || c !== 32'd5) begin
            bad++;
            $display("FAIL flush_add: got edges=%0d C=%h, want edges=0 C=00000005", e, c);
        end
        alu_op = 5'd0; rD1 = 32'd1; rD2 = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        total++;
        if (out_valid !== 1'b0 || dut_c !== 32'd5) begin
            bad++;
            $display("FAIL flush_drop: got v=%b C=%h, want v=0 C=00000005", out_valid, dut_c);
        end
    endtask

    task automatic test_rst_mid();
        int e; logic [31:0] c; logic fo; bit quiet = 1'b1;
        alu_op = 5'd19; rD1 = $urandom; rD2 = $urandom; alub_sel = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut_c !== 32'd0 || dut_f !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid: got v=%b ready=%b C=%h f=%b, want v=0 ready=1 C=0 f=0",
                     out_valid, in_ready, dut_c, dut_f);
        end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (quiet !== 1'b1) begin
            bad++;
            $display("FAIL rst_quiet: got out_valid after reset, want none");
        end
        do_op(5'd1, 32'd3, 32'd5, 1'b1, e, c, fo);
        total++;
        if (e !== 0 || c !== 32'hFFFF_FFFE) begin
            bad++;
            $display("FAIL rst_sub: got edges=%0d C=%h, want edges=0 C=fffffffe", e, c);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_simple();
        test_back_to_back();
        test_mul_timing();
        test_mul_random();
        test_div();
        test_flush();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
